fwd_hazard_unit: RTL



---
 rtl/fwd_pkg.sv | 23 ++
 rtl/lop_slot.sv | 68 ++++++
 rtl/fwd_hazard_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings and parameter limits for the forwarding/hazard unit and its scoreboard.
package fwd_pkg;

  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_WB  = 2'b01;
  localparam logic [1:0] FW_MEM = 2'b10;
  localparam logic [1:0] FW_EX  = 2'b11;

  localparam int LOP_CNT_W     = 4;
  localparam int LOP_LAT_MIN   = 2;
  localparam int LOP_LAT_MAX   = 15;
  localparam int LOP_SLOTS_MIN = 1;
  localparam int LOP_SLOTS_MAX = 8;

  function automatic logic lop_lat_ok(input int lat);
    return (lat >= LOP_LAT_MIN) && (lat <= LOP_LAT_MAX);
  endfunction

  function automatic logic lop_slots_ok(input int slots);
    return (slots >= LOP_SLOTS_MIN) && (slots <= LOP_SLOTS_MAX);
  endfunction

endpackage

// File: rtl/lop_slot.sv
// One scoreboard entry tracking an in-flight long-latency op from issue to write-back.
module lop_slot
  import fwd_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int LOP_LAT = 4
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 alloc,
  input  logic [NB_ADDR-1:0]   rd_in,
  input  logic                 halt,
  output logic                 valid,
  output logic [NB_ADDR-1:0]   rd,
  output logic [LOP_CNT_W-1:0] count,
  output logic                 wb
);

  // Loaded with LAT-1 so the slot is visible for LAT-1 cycles and the
  // write-back lands on issue + LAT-1.
  localparam logic [LOP_CNT_W-1:0] CNT_LOAD = LOP_CNT_W'(LOP_LAT - 1);

  logic                 valid_q, valid_d;
  logic [NB_ADDR-1:0]   rd_q, rd_d;
  logic [LOP_CNT_W-1:0] count_q, count_d;

  // next-state: allocate, count down, retire at count 1; freeze on halt
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (halt) begin
      valid_d = valid_q;
    end else if (alloc) begin
      valid_d = 1'b1;
      rd_d    = rd_in;
      count_d = CNT_LOAD;
    end else if (valid_q) begin
      if (count_q == LOP_CNT_W'(1)) begin
        valid_d = 1'b0;
        count_d = '0;
      end else begin
        count_d = count_q - LOP_CNT_W'(1);
      end
    end else begin
      count_d = '0;
    end
  end

  // slot state register
  always_ff @(posedge clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign valid = valid_q;
  assign rd    = rd_q;
  assign count = count_q;
  assign wb    = valid_q && (count_q == LOP_CNT_W'(1)) && !halt;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage operand forwarding, load-use detection and long-op scoreboard driving the stall line.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NB_ADDR   = 5,
  parameter int NB_FW     = 2,
  parameter int N_SRC     = 2,
  parameter int LOP_SLOTS = 2,
  parameter int LOP_LAT   = 4
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_halt,
  input  logic [N_SRC*NB_ADDR-1:0] i_src_addr,
  input  logic [N_SRC-1:0]         i_src_used,
  input  logic [NB_ADDR-1:0]       i_ex_rd,
  input  logic [NB_ADDR-1:0]       i_mem_rd,
  input  logic [NB_ADDR-1:0]       i_wb_rd,
  input  logic                     i_ex_wr,
  input  logic                     i_mem_wr,
  input  logic                     i_wb_wr,
  input  logic                     i_ex_load,
  input  logic                     i_lop_issue,
  input  logic [NB_ADDR-1:0]       i_lop_rd,
  output logic [N_SRC*NB_FW-1:0]   o_fw_sel,
  output logic                     o_stall,
  output logic                     o_lop_full,
  output logic                     o_lop_wb_valid,
  output logic [NB_ADDR-1:0]       o_lop_wb_rd
);

  if (!lop_lat_ok(LOP_LAT) || !lop_slots_ok(LOP_SLOTS)) begin : g_bad_param
    $error("fwd_hazard_unit: LOP_LAT or LOP_SLOTS out of range");
  end

  logic [NB_ADDR-1:0]   src_a      [N_SRC];
  logic [NB_ADDR-1:0]   slot_rd    [LOP_SLOTS];
  logic [LOP_CNT_W-1:0] slot_count [LOP_SLOTS];
  logic [LOP_SLOTS-1:0] slot_valid, slot_wb, slot_alloc;
  logic                 load_use, raw, waw, full, any_free, accept, found;
  logic [N_SRC*NB_FW-1:0] fw_sel;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign src_a[k] = i_src_addr[k*NB_ADDR +: NB_ADDR];
  end

  // per-channel forward select, load-use and RAW-against-scoreboard detection
  always_comb begin
    fw_sel   = '0;
    load_use = 1'b0;
    raw      = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (i_src_used[k] && (src_a[k] != '0)) begin
        if (i_ex_wr && !i_ex_load && (i_ex_rd == src_a[k])) begin
          fw_sel[k*NB_FW +: NB_FW] = NB_FW'(FW_EX);
        end else if (i_mem_wr && (i_mem_rd == src_a[k])) begin
          fw_sel[k*NB_FW +: NB_FW] = NB_FW'(FW_MEM);
        end else if (i_wb_wr && (i_wb_rd == src_a[k])) begin
          fw_sel[k*NB_FW +: NB_FW] = NB_FW'(FW_WB);
        end else begin
          fw_sel[k*NB_FW +: NB_FW] = NB_FW'(FW_RF);
        end
        if (i_ex_wr && i_ex_load && (i_ex_rd == src_a[k])) begin
          load_use = 1'b1;
        end else begin
          load_use = load_use;
        end
        for (int s = 0; s < LOP_SLOTS; s++) begin
          if (slot_valid[s] && (slot_rd[s] == src_a[k])) begin
            raw = 1'b1;
          end else begin
            raw = raw;
          end
        end
      end else begin
        fw_sel[k*NB_FW +: NB_FW] = NB_FW'(FW_RF);
      end
    end
  end

  // scoreboard issue control: WAW, full, lowest-free allocation, write-back pick
  always_comb begin
    waw            = 1'b0;
    any_free       = 1'b0;
    found          = 1'b0;
    slot_alloc     = '0;
    o_lop_wb_valid = 1'b0;
    o_lop_wb_rd    = '0;
    for (int s = 0; s < LOP_SLOTS; s++) begin
      // a slot is reusable only once both its valid bit and counter agree it is idle
      if (!slot_valid[s] && (slot_count[s] == '0)) begin
        any_free = 1'b1;
      end else begin
        any_free = any_free;
      end
      if (i_lop_issue && (i_lop_rd != '0) && slot_valid[s] && (slot_rd[s] == i_lop_rd)) begin
        waw = 1'b1;
      end else begin
        waw = waw;
      end
    end
    full   = i_lop_issue && !any_free;
    accept = i_lop_issue && !(load_use || raw || waw || full) && !i_halt;
    for (int s = 0; s < LOP_SLOTS; s++) begin
      if (accept && !found && !slot_valid[s] && (slot_count[s] == '0)) begin
        slot_alloc[s] = 1'b1;
        found         = 1'b1;
      end else begin
        slot_alloc[s] = 1'b0;
      end
    end
    for (int s = LOP_SLOTS - 1; s >= 0; s--) begin
      if (slot_wb[s]) begin
        o_lop_wb_valid = 1'b1;
        o_lop_wb_rd    = slot_rd[s];
      end else begin
        o_lop_wb_valid = o_lop_wb_valid;
      end
    end
  end

  for (genvar s = 0; s < LOP_SLOTS; s++) begin : g_slot
    lop_slot #(
      .NB_ADDR (NB_ADDR),
      .LOP_LAT (LOP_LAT)
    ) u_slot (
      .clk   (clk),
      .i_rst (i_rst),
      .alloc (slot_alloc[s]),
      .rd_in (i_lop_rd),
      .halt  (i_halt),
      .valid (slot_valid[s]),
      .rd    (slot_rd[s]),
      .count (slot_count[s]),
      .wb    (slot_wb[s])
    );
  end

  assign o_fw_sel   = fw_sel;
  assign o_lop_full = full;
  assign o_stall    = load_use || raw || waw || full;

endmodule
